i2s_rx: RTL

I2S_RX -- requirements
Module: i2s_rx

---
 rtl/audio_pkg.sv | 13 +
 rtl/sync_edge_det.sv | 39 +++
 rtl/i2s_rx.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared audio definitions used by the I2S receiver and transmitter.
// Holds the default channel word width and the framing FSM encoding.
package audio_pkg;

    localparam int AUDIO_DW_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } i2s_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for one edge-detected line plus W level-only lines.
// All lines share the same latency, so sampled levels line up with the detected rise.
module sync_edge_det #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         edge_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] d_sync_o,
    output logic         rise_o
);

    logic         edge_meta_q;
    logic         edge_sync_q;
    logic         edge_dly_q;
    logic [W-1:0] d_meta_q;
    logic [W-1:0] d_sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            edge_meta_q <= 1'b0;
            edge_sync_q <= 1'b0;
            edge_dly_q  <= 1'b0;
            d_meta_q    <= '0;
            d_sync_q    <= '0;
        end else begin
            edge_meta_q <= edge_i;
            edge_sync_q <= edge_meta_q;
            edge_dly_q  <= edge_sync_q;
            d_meta_q    <= d_i;
            d_sync_q    <= d_meta_q;
        end
    end

    assign d_sync_o = d_sync_q;
    assign rise_o   = edge_sync_q & ~edge_dly_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples sck/ws/sd on clk, aligns to the left channel and
// delivers stereo frames through a valid/ready handshake with sticky error flags.
module i2s_rx
    import audio_pkg::*;
#(
    parameter int AUDIO_DW = AUDIO_DW_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic                sck_i,
    input  logic                ws_i,
    input  logic                sd_i,
    output logic [AUDIO_DW-1:0] l_data_o,
    output logic [AUDIO_DW-1:0] r_data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                locked_o,
    output logic                overrun_o,
    output logic                len_err_o,
    input  logic                clr_err_i
);

    localparam int            CW       = $clog2(AUDIO_DW + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(AUDIO_DW);

    logic       sck_rise;
    logic [1:0] pins_sync;
    logic       ws_s;
    logic       sd_s;

    sync_edge_det #(
        .W(2)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .edge_i  (sck_i),
        .d_i     ({sd_i, ws_i}),
        .d_sync_o(pins_sync),
        .rise_o  (sck_rise)
    );

    assign ws_s = pins_sync[0];
    assign sd_s = pins_sync[1];

    i2s_state_e          state_q, state_d;
    logic                prev_ws_q, prev_ws_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                extra_q, extra_d;
    logic [AUDIO_DW-1:0] word_q, word_d;
    logic [AUDIO_DW-1:0] l_hold_q, l_hold_d;
    logic [AUDIO_DW-1:0] l_data_q, l_data_d;
    logic [AUDIO_DW-1:0] r_data_q, r_data_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;
    logic                len_err_q, len_err_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_HUNT;
            prev_ws_q <= 1'b0;
            cnt_q     <= '0;
            extra_q   <= 1'b0;
            word_q    <= '0;
            l_hold_q  <= '0;
            l_data_q  <= '0;
            r_data_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_ws_q <= prev_ws_d;
            cnt_q     <= cnt_d;
            extra_q   <= extra_d;
            word_q    <= word_d;
            l_hold_q  <= l_hold_d;
            l_data_q  <= l_data_d;
            r_data_q  <= r_data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            len_err_q <= len_err_d;
        end
    end

    logic [AUDIO_DW-1:0] word_in;
    logic [CW-1:0]       cnt_in;
    logic                extra_in;
    logic                ws_edge;
    logic                len_bad;
    logic                frame_done;
    logic                set_len;
    logic                set_ovr;

    always_comb begin
        state_d    = state_q;
        prev_ws_d  = prev_ws_q;
        cnt_d      = cnt_q;
        extra_d    = extra_q;
        word_d     = word_q;
        l_hold_d   = l_hold_q;
        l_data_d   = l_data_q;
        r_data_d   = r_data_q;
        valid_d    = valid_q;
        word_in    = word_q;
        cnt_in     = cnt_q;
        extra_in   = extra_q;
        frame_done = 1'b0;
        set_len    = 1'b0;
        set_ovr    = 1'b0;

        // Bits land at their final position, so short words keep zero LSBs
        // and bits beyond the word width only raise the overflow marker.
        for (int i = 0; i < AUDIO_DW; i++) begin
            if (cnt_q == CW'(AUDIO_DW - 1 - i)) begin
                word_in[i] = sd_s;
            end
        end
        if (cnt_q == FULL_CNT) begin
            extra_in = 1'b1;
        end else begin
            cnt_in = cnt_q + 1'b1;
        end

        ws_edge = (ws_s != prev_ws_q);
        len_bad = extra_in || (cnt_in != FULL_CNT);

        if (sck_rise) begin
            prev_ws_d = ws_s;
        end

        if (!en_i) begin
            state_d = ST_HUNT;
        end else if (sck_rise) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (prev_ws_q && !ws_s) begin
                        state_d = ST_LEFT;
                        word_d  = '0;
                        cnt_d   = '0;
                        extra_d = 1'b0;
                    end
                end
                ST_LEFT, ST_RIGHT: begin
                    if (ws_edge) begin
                        set_len = len_bad;
                        word_d  = '0;
                        cnt_d   = '0;
                        extra_d = 1'b0;
                        if (state_q == ST_LEFT) begin
                            l_hold_d = word_in;
                            state_d  = ST_RIGHT;
                        end else begin
                            frame_done = 1'b1;
                            state_d    = ST_LEFT;
                        end
                    end else begin
                        word_d  = word_in;
                        cnt_d   = cnt_in;
                        extra_d = extra_in;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end

        // A completed frame may replace the presented one only if it is consumed now.
        if (frame_done) begin
            if (!valid_q || ready_i) begin
                l_data_d = l_hold_q;
                r_data_d = word_in;
                valid_d  = 1'b1;
            end else begin
                set_ovr = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        overrun_d = (overrun_q && !clr_err_i) || set_ovr;
        len_err_d = (len_err_q && !clr_err_i) || set_len;
    end

    assign l_data_o  = l_data_q;
    assign r_data_o  = r_data_q;
    assign valid_o   = valid_q;
    assign locked_o  = (state_q != ST_HUNT);
    assign overrun_o = overrun_q;
    assign len_err_o = len_err_q;

endmodule
